ccff_chain_loader: RTL and testbench

// - Configuration-chain controller for a CLB logic tile: takes bitstream words over valid/ready, serialises them LSB-first onto ccff_head.
// - Gates chain advance via chain_clk_en (drives the ICG in front of the tile's prog_clk); chain advances only when it is 1.
// - Optional verify pass: host re-sends the same stream; ccff_tail is compared bit-for-bit against the re-sent bits.

---
 rtl/ccff_loader_pkg.sv | 18 +
 rtl/ccff_chain_loader_piso.sv | 56 +++++
 rtl/ccff_chain_loader.sv | 153 +++++++++++++++
 tb/tb_ccff_chain_loader.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ccff_loader_pkg.sv
// Shared types and helpers for the configuration-chain loader.
package ccff_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_VERIFY = 2'd2,
    ST_FINISH = 2'd3
  } state_e;

  localparam int CNT_W_DEF = 16;

  // Number of bitstream words needed to fill the chain once.
  function automatic int WORDS_PER_PASS(input int chain_len, input int word_w);
    return (chain_len + word_w - 1) / word_w;
  endfunction

endpackage

// File: rtl/ccff_chain_loader_piso.sv
// Word holding register: parallel load, LSB-first shift, tracks how many
// bits are still valid so a truncated final word never shifts its upper bits.
module ccff_word_piso #(
  parameter int WORD_W = 8,
  parameter int BC_W   = $clog2(WORD_W + 1)
) (
  input  logic              prog_clk,
  input  logic              pReset_n,
  input  logic              load_i,
  input  logic [WORD_W-1:0] load_data_i,
  input  logic [BC_W-1:0]   load_bits_i,
  input  logic              shift_i,
  input  logic              flush_i,
  output logic              bit_o,
  output logic              empty_o,
  output logic              last_o
);

  logic [WORD_W-1:0] data_q, data_d;
  logic [BC_W-1:0]   cnt_q, cnt_d;

  // Next holding-register contents: flush beats load, load beats plain shift.
  always_comb begin
    data_d = data_q;
    cnt_d  = cnt_q;
    if (flush_i) begin
      data_d = '0;
      cnt_d  = '0;
    end else if (load_i) begin
      data_d = load_data_i;
      cnt_d  = load_bits_i;
    end else if (shift_i) begin
      data_d = data_q >> 1;
      cnt_d  = cnt_q - BC_W'(1);
    end else begin
      data_d = data_q;
      cnt_d  = cnt_q;
    end
  end

  // Holding register and valid-bit count.
  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bit_o   = data_q[0];
  assign empty_o = (cnt_q == BC_W'(0));
  assign last_o  = (cnt_q == BC_W'(1));

endmodule

// File: rtl/ccff_chain_loader.sv
// Configuration-chain controller: serialises bitstream words onto ccff_head,
// gates the chain clock, and optionally verifies ccff_tail on a second pass.
module ccff_chain_loader
  import ccff_loader_pkg::*;
#(
  parameter int CHAIN_LEN = 20,
  parameter int WORD_W    = 8,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic              prog_clk,
  input  logic              pReset_n,
  input  logic              start,
  input  logic              verify,
  input  logic              abort,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [WORD_W-1:0] s_data,
  output logic              ccff_head,
  output logic              chain_clk_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [CNT_W-1:0]  mismatch_cnt
);

  localparam int BC_W = $clog2(WORD_W + 1);

  state_e           state_q, state_d;
  logic             verify_q, verify_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] mm_q, mm_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0] ld_cnt_q, ld_cnt_d;   // bits already loaded this pass

  logic             p_bit_s, p_empty_s, p_last_s;
  logic             active_s, shift_s, pass_end_s, accept_s;
  logic [CNT_W-1:0] rem_s;
  logic [BC_W-1:0]  load_bits_s;

  assign active_s   = ((state_q == ST_LOAD) || (state_q == ST_VERIFY)) && !abort;
  assign shift_s    = active_s && !p_empty_s;
  assign pass_end_s = shift_s && (bit_cnt_q == CNT_W'(CHAIN_LEN - 1));
  assign rem_s      = CNT_W'(CHAIN_LEN) - ld_cnt_q;
  assign load_bits_s = (rem_s >= CNT_W'(WORD_W)) ? BC_W'(WORD_W) : BC_W'(rem_s);
  // Refill when empty, or in the same cycle the last valid bit leaves.
  assign s_ready    = active_s && (ld_cnt_q != CNT_W'(CHAIN_LEN)) &&
                      (p_empty_s || (p_last_s && shift_s));
  assign accept_s   = s_valid && s_ready;

  ccff_word_piso #(.WORD_W(WORD_W), .BC_W(BC_W)) u_piso (
    .prog_clk    (prog_clk),
    .pReset_n    (pReset_n),
    .load_i      (accept_s),
    .load_data_i (s_data),
    .load_bits_i (load_bits_s),
    .shift_i     (shift_s),
    .flush_i     (abort),
    .bit_o       (p_bit_s),
    .empty_o     (p_empty_s),
    .last_o      (p_last_s)
  );

  // Next-state, counters, compare and sticky error; abort overrides all.
  always_comb begin
    state_d   = state_q;
    verify_d  = verify_q;
    err_d     = err_q;
    mm_d      = mm_q;
    bit_cnt_d = bit_cnt_q;
    ld_cnt_d  = ld_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          state_d   = ST_LOAD;
          verify_d  = verify;
          err_d     = 1'b0;
          mm_d      = '0;
          bit_cnt_d = '0;
          ld_cnt_d  = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD, ST_VERIFY: begin
        if (accept_s) begin
          ld_cnt_d = ld_cnt_q + CNT_W'(load_bits_s);
        end else begin
          ld_cnt_d = ld_cnt_q;
        end
        if (shift_s) begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end else begin
          bit_cnt_d = bit_cnt_q;
        end
        if ((state_q == ST_VERIFY) && shift_s && (ccff_tail != p_bit_s)) begin
          err_d = 1'b1;
          mm_d  = (mm_q == {CNT_W{1'b1}}) ? mm_q : mm_q + CNT_W'(1);
        end else begin
          mm_d  = mm_q;
        end
        if (pass_end_s) begin
          bit_cnt_d = '0;
          ld_cnt_d  = '0;
          state_d   = ((state_q == ST_LOAD) && verify_q) ? ST_VERIFY : ST_FINISH;
        end else begin
          state_d   = state_q;
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    if (abort) begin
      state_d   = ST_IDLE;
      bit_cnt_d = '0;
      ld_cnt_d  = '0;
      if (state_q != ST_IDLE) begin
        err_d = 1'b1;
      end else begin
        err_d = err_q;
      end
    end else begin
      ld_cnt_d = ld_cnt_d;
    end
  end

  // Controller state registers.
  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      state_q   <= ST_IDLE;
      verify_q  <= 1'b0;
      err_q     <= 1'b0;
      mm_q      <= '0;
      bit_cnt_q <= '0;
      ld_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      verify_q  <= verify_d;
      err_q     <= err_d;
      mm_q      <= mm_d;
      bit_cnt_q <= bit_cnt_d;
      ld_cnt_q  <= ld_cnt_d;
    end
  end

  assign ccff_head    = shift_s & p_bit_s;
  assign chain_clk_en = shift_s;
  assign busy         = (state_q != ST_IDLE);
  assign done         = (state_q == ST_FINISH) && !err_q && !abort;
  assign err          = err_q;
  assign mismatch_cnt = mm_q;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Directed + randomized bench for ccff_chain_loader with an external
// 20-flop chain model on ccff_head/ccff_tail.
module tb_ccff_chain_loader;
  import ccff_loader_pkg::*;

  localparam int CL = 20;
  localparam int WW = 8;
  localparam int NW = WORDS_PER_PASS(CL, WW);
  localparam int SW = NW * WW;

  logic          prog_clk;
  logic          pReset_n;
  logic          start, verify, abort, s_valid;
  logic [WW-1:0] s_data;
  logic          s_ready, ccff_head, chain_clk_en, ccff_tail, busy, done, err;
  logic [15:0]   mismatch_cnt;

  int vectors = 0;
  int miscompares = 0;

  // Chain model and event monitor state (written only by the monitor).
  logic [CL-1:0] chain = '0;
  int   shifts = 0;
  int   done_cnt = 0;
  int   run_len = 0;
  logic prev_en = 1'b0;
  logic done_after_shift = 1'b0;

  ccff_chain_loader #(.CHAIN_LEN(CL), .WORD_W(WW), .CNT_W(16)) dut (
    .prog_clk     (prog_clk),
    .pReset_n     (pReset_n),
    .start        (start),
    .verify       (verify),
    .abort        (abort),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .ccff_head    (ccff_head),
    .chain_clk_en (chain_clk_en),
    .ccff_tail    (ccff_tail),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .mismatch_cnt (mismatch_cnt)
  );

  initial prog_clk = 1'b0;
  always #5 prog_clk = ~prog_clk;

  assign ccff_tail = chain[0];

  // Chain shifts head-first toward the tail; also tracks shift runs and done pulses.
  always @(posedge prog_clk) begin
    prev_en <= chain_clk_en;
    if (chain_clk_en) begin
      chain   <= {ccff_head, chain[CL-1:1]};
      shifts  <= shifts + 1;
      run_len <= prev_en ? run_len + 1 : 1;
    end
    if (done) begin
      done_cnt         <= done_cnt + 1;
      done_after_shift <= prev_en;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic v);
    start = 1'b1; verify = v;
    @(negedge prog_clk);
    start = 1'b0; verify = 1'b0;
  endtask

  task automatic send_word(input logic [WW-1:0] w, input int gap);
    int t;
    t = 0;
    s_valid = 1'b1; s_data = w;
    while (!s_ready && t < 200) begin
      @(negedge prog_clk);
      t++;
    end
    if (t >= 200) check("ready_timeout", 32'(t), 32'd0);
    @(negedge prog_clk);
    s_valid = 1'b0; s_data = '0;
    repeat (gap) @(negedge prog_clk);
  endtask

  task automatic send_stream(input logic [SW-1:0] st, input int gap);
    for (int i = 0; i < NW; i++) send_word(st[i*WW +: WW], gap);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (busy && t < 300) begin
      @(negedge prog_clk);
      t++;
    end
    check("idle_timeout", 32'(busy), 32'd0);
  endtask

  // Expected chain contents: first CL bits of the stream, word 0 bit 0 first.
  function automatic logic [CL-1:0] ref_chain(input logic [SW-1:0] st);
    return st[CL-1:0];
  endfunction

  function automatic int ref_mismatch(input logic [SW-1:0] a, input logic [SW-1:0] b);
    logic [SW-1:0] x;
    x = a ^ b;
    return $countones(x[CL-1:0]);
  endfunction

  task automatic run_load(input string tag, input logic [SW-1:0] st, input int gap);
    int s0, d0;
    s0 = shifts; d0 = done_cnt;
    do_start(1'b0);
    send_stream(st, gap);
    wait_idle();
    repeat (2) @(negedge prog_clk);
    check({tag, "_shifts"}, 32'(shifts - s0), 32'(CL));
    check({tag, "_chain"}, 32'(chain), 32'(ref_chain(st)));
    check({tag, "_done"}, 32'(done_cnt - d0), 32'd1);
    check({tag, "_err"}, 32'(err), 32'd0);
  endtask

  task automatic run_verify(input string tag, input logic [SW-1:0] st1, input logic [SW-1:0] st2);
    int s0, d0, mm;
    s0 = shifts; d0 = done_cnt;
    mm = ref_mismatch(st1, st2);
    do_start(1'b1);
    send_stream(st1, 0);
    send_stream(st2, 0);
    wait_idle();
    repeat (2) @(negedge prog_clk);
    check({tag, "_shifts"}, 32'(shifts - s0), 32'(2 * CL));
    check({tag, "_mmcnt"}, 32'(mismatch_cnt), 32'(mm));
    check({tag, "_err"}, 32'(err), 32'(mm != 0));
    check({tag, "_done"}, 32'(done_cnt - d0), 32'(mm == 0));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_s_ready"}, 32'(s_ready), 32'd0);
    check({tag, "_head"}, 32'(ccff_head), 32'd0);
    check({tag, "_clk_en"}, 32'(chain_clk_en), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_mmcnt"}, 32'(mismatch_cnt), 32'd0);
  endtask

  initial begin
    logic [SW-1:0] st, st2;
    int s0, d0, t;
    pReset_n = 1'b0; start = 1'b0; verify = 1'b0; abort = 1'b0;
    s_valid = 1'b0; s_data = '0;
    repeat (3) @(negedge prog_clk);
    check_reset_outputs("reset");
    pReset_n = 1'b1;
    @(negedge prog_clk);

    // Load only, back-to-back words.
    run_load("load", 24'h0F3CA5, 0);
    check("load_consecutive", 32'(run_len), 32'(CL));
    check("load_done_latency", 32'(done_after_shift), 32'd1);

    // Randomized loads with random stalls.
    for (int i = 0; i < 4; i++) begin
      st = SW'($urandom);
      run_load("rand_load", st, int'($urandom_range(0, 4)));
    end

    // Long stalls between words leave the chain idle but give the same result.
    run_load("stall", 24'h0F3CA5, 10);
    check("stall_gapped", 32'(run_len < CL), 32'd1);

    // Upper nibble of the last word is never shifted.
    run_load("nibble", 24'hFF3CA5, 0);

    // Verify passes: identical, single-bit mismatch, random flips.
    run_verify("verify_ok", 24'h0F3CA5, 24'h0F3CA5);
    run_verify("verify_mm", 24'h0F3CA5, 24'h0F3CA4);
    for (int i = 0; i < 3; i++) begin
      st  = SW'($urandom);
      st2 = st ^ (SW'($urandom) & SW'($urandom) & SW'($urandom));
      run_verify("rand_verify", st, st2);
    end

    // Abort after 10 shifts.
    s0 = shifts; d0 = done_cnt;
    do_start(1'b0);
    s_valid = 1'b1; s_data = 8'hA5;
    t = 0;
    while ((shifts - s0) < 10 && t < 100) begin
      @(negedge prog_clk);
      t++;
    end
    check("abort_reach10", 32'(shifts - s0), 32'd10);
    abort = 1'b1;
    #1;
    check("abort_clk_en", 32'(chain_clk_en), 32'd0);
    check("abort_s_ready_now", 32'(s_ready), 32'd0);
    @(negedge prog_clk);
    abort = 1'b0; s_valid = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_err", 32'(err), 32'd1);
    check("abort_s_ready", 32'(s_ready), 32'd0);
    repeat (5) @(negedge prog_clk);
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);
    check("abort_shift_stop", 32'(shifts - s0), 32'd10);
    do_start(1'b0);
    check("start_clears_err", 32'(err), 32'd0);
    send_stream(24'h0F3CA5, 0);
    wait_idle();
    repeat (2) @(negedge prog_clk);
    check("post_abort_chain", 32'(chain), 32'h0F3CA5);
    check("post_abort_done", 32'(done_cnt - d0), 32'd1);

    // Abort in IDLE leaves err untouched.
    abort = 1'b1;
    @(negedge prog_clk);
    abort = 1'b0;
    check("abort_idle_err", 32'(err), 32'd0);

    // Start while busy is ignored: stays a load-only pass.
    s0 = shifts; d0 = done_cnt;
    st = SW'($urandom);
    do_start(1'b0);
    send_word(st[7:0], 0);
    start = 1'b1; verify = 1'b1;
    @(negedge prog_clk);
    start = 1'b0; verify = 1'b0;
    send_word(st[15:8], 0);
    send_word(st[23:16], 0);
    wait_idle();
    repeat (2) @(negedge prog_clk);
    check("busy_start_shifts", 32'(shifts - s0), 32'(CL));
    check("busy_start_chain", 32'(chain), 32'(ref_chain(st)));
    check("busy_start_done", 32'(done_cnt - d0), 32'd1);

    // Reset mid-LOAD.
    do_start(1'b1);
    send_word(8'h5A, 0);
    repeat (3) @(negedge prog_clk);
    check("midload_busy", 32'(busy), 32'd1);
    pReset_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(negedge prog_clk);
    pReset_n = 1'b1;
    @(negedge prog_clk);
    check("after_reset_busy", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
